// File: rtl/mux_sel_scheduler.sv
// -----------------------------------------------------------------------------
// mux_sel_scheduler
//   Round-robin grant scheduler that drives the select lines of a downstream
//   4:1 data mux. A grant is held for up to DWELL cycles or until the consumer
//   signals done. The next channel can be granted on the release edge, so a
//   busy stream of requests sees no idle cycles between grants.
//
// Parameters
//   DWELL      maximum cycles per grant (1..255)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   en         arbitration enable; gates only the start of new grants
//   req[3:0]   per-channel request
//   done       consumer releases the current grant early
//   s0, s1     mux select {s1,s0}; holds the last granted index while idle
//   grant[3:0] one-hot grant, zero when idle
//   busy       a grant is active
//   dwell_cnt  cycles remaining in the current grant (0 when idle)
// -----------------------------------------------------------------------------
module mux_sel_scheduler #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       done,
  output logic       s0,
  output logic       s1,
  output logic [3:0] grant,
  output logic       busy,
  output logic [7:0] dwell_cnt
);

  localparam int         NUM_CH   = 4;
  localparam logic [7:0] DW_LOAD  = 8'(DWELL - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      r_state;
  logic [1:0]  r_ptr;      // next index to search from when idle
  logic [1:0]  r_sel;      // last / current granted index
  logic [3:0]  r_grant;
  logic        r_busy;
  logic [7:0]  r_dwell;

  logic        w_rel;      // current grant ends on this edge
  logic [1:0]  w_base;     // search origin for this edge's arbitration
  logic [3:0]  w_rot;      // requests rotated so bit k is index w_base+k
  logic        w_hit;
  logic [1:0]  w_pick;
  logic        w_start;    // a grant is loaded on this edge

  assign w_rel = (r_state == GRANT) && (done || (r_dwell == 8'd0));

  // On a release edge the pointer is about to become r_sel+1; arbitrate from
  // that value directly so the back-to-back grant already honours it.
  assign w_base = (r_state == GRANT) ? (r_sel + 2'd1) : r_ptr;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_rot
    logic [1:0] w_idx;
    assign w_idx    = w_base + 2'(k);
    assign w_rot[k] = req[w_idx];
  end

  // Lowest rotated position wins; scanning high-to-low lets the last hit stick.
  always_comb begin
    w_hit  = 1'b0;
    w_pick = w_base;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_hit  = 1'b1;
        w_pick = w_base + 2'(k);
      end
    end
  end

  assign w_start = en && w_hit && ((r_state == IDLE) || w_rel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_sel   <= 2'd0;
      r_grant <= 4'b0000;
      r_busy  <= 1'b0;
      r_dwell <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= GRANT;
            r_sel   <= w_pick;
            r_grant <= 4'b0001 << w_pick;
            r_busy  <= 1'b1;
            r_dwell <= DW_LOAD;
          end
        end
        GRANT: begin
          if (w_rel) begin
            r_ptr <= r_sel + 2'd1;
            if (w_start) begin
              r_sel   <= w_pick;
              r_grant <= 4'b0001 << w_pick;
              r_dwell <= DW_LOAD;
            end else begin
              // r_sel is left alone so the mux output stays stable while idle
              r_state <= IDLE;
              r_grant <= 4'b0000;
              r_busy  <= 1'b0;
              r_dwell <= 8'd0;
            end
          end else begin
            // w_rel covers dwell==0, so this never underflows
            r_dwell <= r_dwell - 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 4'b0000;
          r_busy  <= 1'b0;
          r_dwell <= 8'd0;
        end
      endcase
    end
  end

  assign s0        = r_sel[0];
  assign s1        = r_sel[1];
  assign grant     = r_grant;
  assign busy      = r_busy;
  assign dwell_cnt = r_dwell;

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_scheduler
//   Two schedulers (DWELL=4 and DWELL=1) share one set of inputs. Each is
//   compared every cycle with a reference model that tracks "who holds the
//   mux and for how many more cycles", plus directed spot checks.
// -----------------------------------------------------------------------------
module tb_mux_sel_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic       done;

  logic       a_s0, a_s1, a_busy;
  logic [3:0] a_grant;
  logic [7:0] a_dwell;
  logic       b_s0, b_s1, b_busy;
  logic [3:0] b_grant;
  logic [7:0] b_dwell;

  int n_chk  = 0;
  int n_fail = 0;

  mux_sel_scheduler #(.DWELL(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .s0(a_s0), .s1(a_s1), .grant(a_grant), .busy(a_busy), .dwell_cnt(a_dwell)
  );

  mux_sel_scheduler #(.DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .s0(b_s0), .s1(b_s1), .grant(b_grant), .busy(b_busy), .dwell_cnt(b_dwell)
  );

  always #5 clk = ~clk;

  // reference model state, index 0 -> dut_a, 1 -> dut_b
  int dw     [2] = '{4, 1};
  int m_busy [2];
  int m_owner[2];
  int m_left [2];
  int m_next [2];
  int m_mux  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_busy[u] = 0; m_owner[u] = 0; m_left[u] = 0; m_next[u] = 0; m_mux[u] = 0;
    end
  endtask

  // One clock edge: finish or continue the current holder, then hand the mux
  // to the first requester at or after the round-robin position.
  task automatic model_step();
    for (int u = 0; u < 2; u++) begin
      bit free;
      free = (m_busy[u] == 0);
      if (m_busy[u] != 0) begin
        if (done || m_left[u] == 0) begin
          m_next[u] = (m_owner[u] + 1) % 4;
          free = 1;
        end else begin
          m_left[u] = m_left[u] - 1;
        end
      end
      if (free) begin
        int who;
        who = -1;
        if (en) begin
          for (int k = 0; k < 4; k++)
            if (who < 0 && req[(m_next[u] + k) % 4]) who = (m_next[u] + k) % 4;
        end
        if (who >= 0) begin
          m_busy[u] = 1; m_owner[u] = who; m_left[u] = dw[u] - 1; m_mux[u] = who;
        end else begin
          m_busy[u] = 0; m_left[u] = 0;
        end
      end
    end
  endtask

  function automatic logic [3:0] exp_grant(int u);
    return (m_busy[u] != 0) ? 4'(1 << m_owner[u]) : 4'b0000;
  endfunction

  task automatic check_all();
    chk("a_grant", 32'(a_grant), 32'(exp_grant(0)));
    chk("a_sel",   32'({a_s1, a_s0}), 32'(m_mux[0]));
    chk("a_busy",  32'(a_busy), 32'(m_busy[0]));
    chk("a_dwell", 32'(a_dwell), 32'(m_left[0]));
    chk("b_grant", 32'(b_grant), 32'(exp_grant(1)));
    chk("b_sel",   32'({b_s1, b_s0}), 32'(m_mux[1]));
    chk("b_busy",  32'(b_busy), 32'(m_busy[1]));
    chk("b_dwell", 32'(b_dwell), 32'(m_left[1]));
  endtask

  // inputs change at negedge; outputs checked at negedge
  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req = 4'b0000; done = 1'b0;
    #1;
    model_reset();
    check_all();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; req = 4'b0000; done = 1'b0;
    model_reset();
    @(negedge clk);

    // reset state
    do_reset();
    chk("rst_grant", 32'(a_grant), 32'h0);
    chk("rst_sel",   32'({a_s1, a_s0}), 32'h0);

    // all channels requesting: 0,1,2,3,0 each for 4 cycles, no gaps
    en = 1'b1; req = 4'b1111;
    cyc();
    for (int g = 0; g < 5; g++) begin
      chk("rr_grant", 32'(a_grant), 32'(1 << (g % 4)));
      chk("rr_sel",   32'({a_s1, a_s0}), 32'(g % 4));
      for (int c = 0; c < 4; c++) begin
        chk("rr_busy", 32'(a_busy), 32'h1);
        cyc();
      end
    end

    // lone request on channel 2, then idle holding select
    do_reset();
    en = 1'b1; req = 4'b0100;
    cyc();
    req = 4'b0000;
    chk("lone_grant", 32'(a_grant), 32'h4);
    chk("lone_sel",   32'({a_s1, a_s0}), 32'h2);
    repeat (4) cyc();
    chk("lone_busy", 32'(a_busy), 32'h0);
    chk("lone_hold", 32'({a_s1, a_s0}), 32'h2);

    // early done on channel 1, next grant skips idle channel 2
    do_reset();
    en = 1'b1; req = 4'b1010;
    cyc();
    chk("done_g1", 32'(a_grant), 32'h2);
    cyc();
    done = 1'b1;
    cyc();
    done = 1'b0;
    chk("done_next", 32'(a_grant), 32'h8);
    chk("done_sel",  32'({a_s1, a_s0}), 32'h3);

    // en dropped mid-grant: grant 0 runs its full dwell, then idle
    do_reset();
    en = 1'b1; req = 4'b0001;
    cyc();
    en = 1'b0; req = 4'b1111;
    repeat (3) cyc();
    chk("en_hold",  32'(a_grant), 32'h1);
    chk("en_dwell", 32'(a_dwell), 32'h0);
    cyc();
    chk("en_idle_busy",  32'(a_busy), 32'h0);
    chk("en_idle_grant", 32'(a_grant), 32'h0);
    cyc();
    chk("en_stay_idle", 32'(a_grant), 32'h0);

    // asynchronous reset mid-grant on channel 2
    do_reset();
    en = 1'b1; req = 4'b0100;
    cyc();
    chk("ar_pre", 32'(a_grant), 32'h4);
    @(posedge clk);
    model_step();
    #2 rst = 1'b1;
    #1 model_reset();
    chk("ar_grant", 32'(a_grant), 32'h0);
    chk("ar_busy",  32'(a_busy), 32'h0);
    chk("ar_sel",   32'({a_s1, a_s0}), 32'h0);
    chk("ar_dwell", 32'(a_dwell), 32'h0);
    @(negedge clk);
    rst = 1'b0; req = 4'b1111;
    cyc();
    chk("ar_first", 32'(a_grant), 32'h1);

    // DWELL=1 alternates 0,3,0,3
    do_reset();
    en = 1'b1; req = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("d1_alt", 32'(b_grant), (i % 2) ? 32'h8 : 32'h1);
    end

    // random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 59) == 0);
      en   = ($urandom_range(0, 3) != 0);
      req  = 4'($urandom);
      done = ($urandom_range(0, 4) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
